// File: rtl/csr_pkg.sv
// Shared CSR addresses, masks, response codes and responder states for the
// machine-mode CSR file.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [2:0]  BRESP_OK      = 3'd0;

   localparam logic [31:0] MEPC_MASK     = 32'hFFFF_FFFC;
   localparam logic [31:0] MTVEC_MASK    = 32'hFFFF_FFFD;

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} resp_state_e;

   // Read-only space (addr[11:10] == 2'b11) never appears in this list.
   function automatic logic csr_writable(input logic [11:0] a);
      case (a)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
            return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping event counter with independently writable 32-bit halves.
// A write to either half takes priority over the increment in that cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   logic [63:0] r_value;

   always_ff @(posedge clk) begin
      if (reset)      r_value <= '0;
      else if (wr_lo) r_value[31:0]  <= wdata;
      else if (wr_hi) r_value[63:32] <= wdata;
      else if (inc)   r_value <= r_value + 64'd1;
   end

   assign value = r_value;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR storage: write-bus responder, combinational read port,
// trap-state capture and the cycle/instret counters.
module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] HART_ID   = 32'd0,
   parameter logic [2:0]  BRESP_ERR = 3'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] csrbus_waddr,
   input  logic [31:0] csrbus_wdata,
   input  logic        csrbus_wvalid,
   output logic        csrbus_wready,
   output logic [2:0]  csrbus_bresp,
   output logic        csrbus_bvalid,
   input  logic        csrbus_bready,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic        csr_rvalid,
   input  logic        commit_valid,
   input  logic        exception_valid,
   input  logic [5:0]  exception_num,
   input  logic [31:0] exception_val,
   input  logic [31:0] exception_pc,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out
);

   resp_state_e r_state;
   logic        r_wready;
   logic        r_bvalid;
   logic [2:0]  r_bresp;

   logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
   logic [63:0] w_mcycle, w_minstret;

   logic w_accept, w_legal, w_wr;

   assign w_accept = (r_state == IDLE) && csrbus_wvalid;
   assign w_legal  = csr_writable(csrbus_waddr);
   assign w_wr     = w_accept && w_legal;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_wready <= 1'b1;
         r_bvalid <= 1'b0;
         r_bresp  <= BRESP_OK;
      end else begin
         unique case (r_state)
            IDLE: if (csrbus_wvalid) begin
               r_state  <= RESP;
               r_wready <= 1'b0;
               r_bvalid <= 1'b1;
               r_bresp  <= w_legal ? BRESP_OK : BRESP_ERR;
            end
            RESP: if (csrbus_bready) begin
               r_state  <= IDLE;
               r_wready <= 1'b1;
               r_bvalid <= 1'b0;
            end
         endcase
      end
   end

   assign csrbus_wready = r_wready;
   assign csrbus_bvalid = r_bvalid;
   assign csrbus_bresp  = r_bresp;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mstatus  <= '0;
         r_mie      <= '0;
         r_mtvec    <= '0;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
      end else begin
         if (w_wr) begin
            case (csrbus_waddr)
               CSR_MSTATUS:  r_mstatus  <= csrbus_wdata;
               CSR_MIE:      r_mie      <= csrbus_wdata;
               CSR_MTVEC:    r_mtvec    <= csrbus_wdata & MTVEC_MASK;
               CSR_MSCRATCH: r_mscratch <= csrbus_wdata;
               CSR_MEPC:     r_mepc     <= csrbus_wdata & MEPC_MASK;
               CSR_MCAUSE:   r_mcause   <= {26'b0, csrbus_wdata[5:0]};
               CSR_MTVAL:    r_mtval    <= csrbus_wdata;
               default: ;
            endcase
         end
         // Later assignments win: a committed trap overrides a same-cycle bus write.
         if (exception_valid) begin
            r_mepc   <= exception_pc & MEPC_MASK;
            r_mcause <= {26'b0, exception_num};
            r_mtval  <= exception_val;
         end
      end
   end

   csr_counter64 u_mcycle (
      .clk   (clk),
      .reset (reset),
      .inc   (1'b1),
      .wr_lo (w_wr && csrbus_waddr == CSR_MCYCLE),
      .wr_hi (w_wr && csrbus_waddr == CSR_MCYCLEH),
      .wdata (csrbus_wdata),
      .value (w_mcycle)
   );

   csr_counter64 u_minstret (
      .clk   (clk),
      .reset (reset),
      .inc   (commit_valid),
      .wr_lo (w_wr && csrbus_waddr == CSR_MINSTRET),
      .wr_hi (w_wr && csrbus_waddr == CSR_MINSTRETH),
      .wdata (csrbus_wdata),
      .value (w_minstret)
   );

   always_comb begin
      csr_rdata  = '0;
      csr_rvalid = 1'b1;
      case (csr_raddr)
         CSR_MSTATUS:                csr_rdata = r_mstatus;
         CSR_MIE:                    csr_rdata = r_mie;
         CSR_MTVEC:                  csr_rdata = r_mtvec;
         CSR_MSCRATCH:               csr_rdata = r_mscratch;
         CSR_MEPC:                   csr_rdata = r_mepc;
         CSR_MCAUSE:                 csr_rdata = r_mcause;
         CSR_MTVAL:                  csr_rdata = r_mtval;
         CSR_MCYCLE,   CSR_CYCLE:    csr_rdata = w_mcycle[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata = w_mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:  csr_rdata = w_minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = w_minstret[63:32];
         CSR_MHARTID:                csr_rdata = HART_ID;
         default:                    csr_rvalid = 1'b0;
      endcase
   end

   assign mtvec_out = r_mtvec;
   assign mepc_out  = r_mepc;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a per-cycle compare against an address-map
// model plus literal expectations for the headline scenarios.
module tb_csr_file;

   localparam logic [31:0] HART = 32'd0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] csrbus_waddr = '0;
   logic [31:0] csrbus_wdata = '0;
   logic        csrbus_wvalid = 1'b0;
   logic        csrbus_wready;
   logic [2:0]  csrbus_bresp;
   logic        csrbus_bvalid;
   logic        csrbus_bready = 1'b0;
   logic [11:0] csr_raddr = '0;
   logic [31:0] csr_rdata;
   logic        csr_rvalid;
   logic        commit_valid = 1'b0;
   logic        exception_valid = 1'b0;
   logic [5:0]  exception_num = '0;
   logic [31:0] exception_val = '0;
   logic [31:0] exception_pc = '0;
   logic [31:0] mtvec_out, mepc_out;

   csr_file #(.HART_ID(HART), .BRESP_ERR(3'd2)) dut (
      .clk(clk), .reset(reset),
      .csrbus_waddr(csrbus_waddr), .csrbus_wdata(csrbus_wdata),
      .csrbus_wvalid(csrbus_wvalid), .csrbus_wready(csrbus_wready),
      .csrbus_bresp(csrbus_bresp), .csrbus_bvalid(csrbus_bvalid),
      .csrbus_bready(csrbus_bready),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
      .commit_valid(commit_valid), .exception_valid(exception_valid),
      .exception_num(exception_num), .exception_val(exception_val),
      .exception_pc(exception_pc), .mtvec_out(mtvec_out), .mepc_out(mepc_out)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: plain storage for the simple CSRs, 64-bit counters, and a
   // single "response outstanding" flag for the bus.
   logic [31:0] mr [bit [11:0]];
   logic [63:0] mcyc, mins;
   bit          pend;
   logic [2:0]  mbresp;

   function automatic bit m_writable(input logic [11:0] a);
      return mr.exists(a) || a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82;
   endfunction

   function automatic logic [31:0] m_mask(input logic [11:0] a, input logic [31:0] d);
      if (a == 12'h341) return {d[31:2], 2'b00};
      if (a == 12'h305) return {d[31:2], 1'b0, d[0]};
      if (a == 12'h342) return {26'b0, d[5:0]};
      return d;
   endfunction

   task automatic m_read(input logic [11:0] a, output logic [31:0] v, output logic ok);
      ok = 1'b1;
      case (a)
         12'hB00, 12'hC00: v = mcyc[31:0];
         12'hB80, 12'hC80: v = mcyc[63:32];
         12'hB02, 12'hC02: v = mins[31:0];
         12'hB82, 12'hC82: v = mins[63:32];
         12'hF14:          v = HART;
         default: if (mr.exists(a)) v = mr[a]; else begin v = '0; ok = 1'b0; end
      endcase
   endtask

   initial begin
      logic [11:0] a;
      logic [31:0] d;
      bit acc, ok, wr;
      mr[12'h300] = '0; mr[12'h304] = '0; mr[12'h305] = '0; mr[12'h340] = '0;
      mr[12'h341] = '0; mr[12'h342] = '0; mr[12'h343] = '0;
      mcyc = '0; mins = '0; pend = 1'b0; mbresp = '0;
      forever begin
         @(posedge clk);
         if (reset) begin
            foreach (mr[k]) mr[k] = '0;
            mcyc = '0; mins = '0; pend = 1'b0; mbresp = '0;
         end else begin
            a   = csrbus_waddr;
            d   = csrbus_wdata;
            acc = !pend && csrbus_wvalid;
            ok  = m_writable(a);
            wr  = acc && ok;
            if (wr && a == 12'hB00)      mcyc = {mcyc[63:32], d};
            else if (wr && a == 12'hB80) mcyc = {d, mcyc[31:0]};
            else                         mcyc = mcyc + 64'd1;
            if (wr && a == 12'hB02)      mins = {mins[63:32], d};
            else if (wr && a == 12'hB82) mins = {d, mins[31:0]};
            else if (commit_valid)       mins = mins + 64'd1;
            if (wr && mr.exists(a)) mr[a] = m_mask(a, d);
            if (exception_valid) begin
               mr[12'h341] = {exception_pc[31:2], 2'b00};
               mr[12'h342] = {26'b0, exception_num};
               mr[12'h343] = exception_val;
            end
            if (pend) begin
               if (csrbus_bready) pend = 1'b0;
            end else if (acc) begin
               pend   = 1'b1;
               mbresp = ok ? 3'd0 : 3'd2;
            end
         end
      end
   end

   initial begin
      logic [31:0] ev;
      logic        evld;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            m_read(csr_raddr, ev, evld);
            chk("rdata",  csr_rdata, ev);
            chk("rvalid", {31'b0, csr_rvalid}, {31'b0, evld});
            chk("wready", {31'b0, csrbus_wready}, {31'b0, !pend});
            chk("bvalid", {31'b0, csrbus_bvalid}, {31'b0, pend});
            if (pend) chk("bresp", {29'b0, csrbus_bresp}, {29'b0, mbresp});
            chk("mtvec_out", mtvec_out, mr[12'h305]);
            chk("mepc_out",  mepc_out,  mr[12'h341]);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
      csr_raddr = a; #1;
      chk(name, csr_rdata, exp);
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
      csrbus_waddr = a; csrbus_wdata = d; csrbus_wvalid = 1'b1;
      tick();
      csrbus_wvalid = 1'b0; csrbus_bready = 1'b1;
      tick();
      csrbus_bready = 1'b0;
   endtask

   initial begin
      logic [31:0] v0;
      tick(); tick();
      cmp_en = 1'b1;
      chk("rst_wready", {31'b0, csrbus_wready}, 32'd1);
      chk("rst_bvalid", {31'b0, csrbus_bvalid}, 32'd0);
      chk("rst_bresp",  {29'b0, csrbus_bresp}, 32'd0);
      chk("rst_mtvec",  mtvec_out, 32'd0);
      chk("rst_mepc",   mepc_out, 32'd0);

      // Three cycles out of reset, two of them with a retirement.
      reset = 1'b0; commit_valid = 1'b1;
      tick(); tick();
      commit_valid = 1'b0;
      tick();
      rd(12'hB00, 32'd3, "mcycle_n");
      rd(12'hC02, 32'd2, "instret_n");
      rd(12'hF14, HART, "mhartid");

      // mepc write with low bits masked
      csrbus_waddr = 12'h341; csrbus_wdata = 32'h1234_5679; csrbus_wvalid = 1'b1;
      tick();
      csrbus_wvalid = 1'b0;
      chk("mepc_bvalid", {31'b0, csrbus_bvalid}, 32'd1);
      chk("mepc_bresp",  {29'b0, csrbus_bresp}, 32'd0);
      rd(12'h341, 32'h1234_5678, "mepc_rd");
      csrbus_bready = 1'b1; tick(); csrbus_bready = 1'b0;

      // mtvec bit 1 forced low
      bus_write(12'h305, 32'hFFFF_FFFF);
      chk("mtvec_mask", mtvec_out, 32'hFFFF_FFFD);

      // read-only shadow write rejected, cycle keeps counting
      csr_raddr = 12'hC00; #1; v0 = csr_rdata;
      csrbus_waddr = 12'hC00; csrbus_wdata = 32'h0; csrbus_wvalid = 1'b1;
      tick();
      csrbus_wvalid = 1'b0;
      chk("ro_bresp", {29'b0, csrbus_bresp}, 32'd2);
      csrbus_bready = 1'b1; tick(); csrbus_bready = 1'b0;
      rd(12'hC00, v0 + 32'd2, "ro_cycle_runs");

      // unimplemented address
      csrbus_waddr = 12'h7C0; csrbus_wdata = 32'hFFFF_FFFF; csrbus_wvalid = 1'b1;
      tick();
      csrbus_wvalid = 1'b0;
      chk("unimp_bresp", {29'b0, csrbus_bresp}, 32'd2);
      csr_raddr = 12'h7C0; #1;
      chk("unimp_rvalid", {31'b0, csr_rvalid}, 32'd0);
      csrbus_bready = 1'b1; tick(); csrbus_bready = 1'b0;

      // bready held low with wvalid still asserted: only the first write lands
      csrbus_waddr = 12'h340; csrbus_wdata = 32'hAAAA_0001; csrbus_wvalid = 1'b1;
      tick();
      csrbus_wdata = 32'hBBBB_0002;
      for (int i = 0; i < 5; i++) begin
         chk("hold_wready", {31'b0, csrbus_wready}, 32'd0);
         chk("hold_bvalid", {31'b0, csrbus_bvalid}, 32'd1);
         chk("hold_bresp",  {29'b0, csrbus_bresp}, 32'd0);
         tick();
      end
      csrbus_wvalid = 1'b0; csrbus_bready = 1'b1; tick(); csrbus_bready = 1'b0;
      rd(12'h340, 32'hAAAA_0001, "hold_single");

      // mcycle low half to all-ones, then one more cycle carries into mcycleh
      bus_write(12'hB00, 32'hFFFF_FFFF);
      rd(12'hB80, 32'd1, "wrap_hi");
      rd(12'hB00, 32'd0, "wrap_lo");

      // trap capture beats a same-cycle mcause write
      csrbus_waddr = 12'h342; csrbus_wdata = 32'd7; csrbus_wvalid = 1'b1;
      exception_valid = 1'b1; exception_num = 6'd2;
      exception_pc = 32'h80; exception_val = 32'hDEAD;
      tick();
      csrbus_wvalid = 1'b0; exception_valid = 1'b0;
      chk("exc_bresp", {29'b0, csrbus_bresp}, 32'd0);
      rd(12'h342, 32'd2, "exc_mcause");
      rd(12'h343, 32'hDEAD, "exc_mtval");
      chk("exc_mepc", mepc_out, 32'h80);
      csrbus_bready = 1'b1; tick(); csrbus_bready = 1'b0;

      // reset in the middle of a transaction
      csrbus_waddr = 12'h300; csrbus_wdata = 32'h55; csrbus_wvalid = 1'b1;
      tick();
      csrbus_wvalid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_bvalid", {31'b0, csrbus_bvalid}, 32'd0);
      chk("rst_mid_wready", {31'b0, csrbus_wready}, 32'd1);
      rd(12'h300, 32'd0, "rst_mid_lost");

      tick(); tick();
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
